// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU/DMA RAM arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_e;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;

  localparam int CNT_W = 3;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way round-robin picker; a held CPU lock grants the CPU exclusively.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  input  logic       lock_held,
  output logic       grant_valid,
  output logic       grant_owner
);

  // req[0] is the CPU, req[1] the DMA port.
  always_comb begin
    grant_valid = 1'b0;
    grant_owner = OWNER_CPU;
    if (lock_held) begin
      grant_valid = req[0];
      grant_owner = OWNER_CPU;
    end else begin
      case (req)
        2'b01: begin
          grant_valid = 1'b1;
          grant_owner = OWNER_CPU;
        end
        2'b10: begin
          grant_valid = 1'b1;
          grant_owner = OWNER_DMA;
        end
        2'b11: begin
          grant_valid = 1'b1;
          grant_owner = ~last_owner;
        end
        default: begin
          grant_valid = 1'b0;
          grant_owner = OWNER_CPU;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-port RAM arbiter between CPU and DMA: serialises accesses, inserts
// read wait states, round-robins on contention and honours a CPU bus lock.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_lock,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              owner
);

  if (RD_LAT < 1 || RD_LAT > 7) begin : g_bad_rd_lat
    $error("mem_bus_arbiter: RD_LAT must be in 1..7");
  end

  localparam logic [CNT_W-1:0] RD_LAT_C = CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  arb_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic              lock_held_q, lock_held_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              dma_ack_q, dma_ack_d;
  logic              busy_q, busy_d;
  logic              grant_valid, grant_owner;

  mem_arb_pick u_pick (
    .req        ({dma_req, cpu_req}),
    .last_owner (last_owner_q),
    .lock_held  (lock_held_q),
    .grant_valid(grant_valid),
    .grant_owner(grant_owner)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = ISSUE; else state_d = IDLE;
      ISSUE:   if (we_q) state_d = ACK; else state_d = WAIT;
      WAIT:    if (cnt_q == CNT_ONE) state_d = ACK; else state_d = WAIT;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes/acks are decoded from the next state so they leave the flops aligned with state_q.
  always_comb begin
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    lock_held_d  = lock_held_q;
    cnt_d        = cnt_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d = grant_owner;
          if (grant_owner == OWNER_CPU) begin
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end else begin
            we_d    = dma_we;
            addr_d  = dma_addr;
            wdata_d = dma_wdata;
          end
        end else begin
          owner_d = owner_q;
        end
      end
      ISSUE: begin
        last_owner_d = owner_q;
        cnt_d        = RD_LAT_C;
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          if (owner_q == OWNER_CPU) begin
            cpu_rdata_d = ram_rdata;
          end else begin
            dma_rdata_d = ram_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ACK: begin
        if (owner_q == OWNER_CPU) begin
          lock_held_d = cpu_lock;
        end else begin
          lock_held_d = lock_held_q;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
    ram_en_d  = (state_d == ISSUE);
    ram_we_d  = (state_d == ISSUE) && we_d;
    cpu_ack_d = (state_d == ACK) && (owner_d == OWNER_CPU);
    dma_ack_d = (state_d == ACK) && (owner_d == OWNER_DMA);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      owner_q      <= OWNER_CPU;
      last_owner_q <= OWNER_DMA;
      lock_held_q  <= 1'b0;
      cnt_q        <= '0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      cpu_ack_q    <= 1'b0;
      dma_ack_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      lock_held_q  <= lock_held_d;
      cnt_q        <= cnt_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      cpu_ack_q    <= cpu_ack_d;
      dma_ack_q    <= dma_ack_d;
      busy_q       <= busy_d;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_ack   = dma_ack_q;
  assign dma_rdata = dma_rdata_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a behavioural RAM and shadow memory
// give expected data; grant order and latency follow the arbitration rules.
module tb_mem_bus_arbiter;

  localparam int LAT = 3;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         exp_en;
  } txn_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  logic       cpu_req, cpu_we, cpu_lock, cpu_ack;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       dma_req, dma_we, dma_ack;
  logic [7:0] dma_addr, dma_wdata, dma_rdata;
  logic       ram_en, ram_we, busy, owner;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;

  logic       c1_req, c1_we, c1_lock, c1_ack;
  logic [7:0] c1_addr, c1_wdata, c1_rdata;
  logic       d1_req, d1_we, d1_ack;
  logic [7:0] d1_addr, d1_wdata, d1_rdata;
  logic       r1_en, r1_we, busy1, owner1;
  logic [7:0] r1_addr, r1_wdata, r1_rdata;

  logic [7:0] mem [256];
  logic [7:0] mem1 [256];
  logic [7:0] pipe [LAT];
  logic [7:0] shadow [256];

  txn_t exp_q [2][$];
  logic grant_log [$];
  int   ack_cnt [2];
  int   ack_snap [2];
  int   ack_cyc [2];
  int   en_cyc [2];
  logic [7:0] last_rd [2];
  bit   mon_en = 1'b0;
  int   errs = 0;
  int   checks = 0;

  txn_t       mt;
  logic       m_ack;
  logic [7:0] m_rd, m_ex;

  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(LAT)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_lock(cpu_lock), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy), .owner(owner)
  );

  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .cpu_req(c1_req), .cpu_we(c1_we), .cpu_addr(c1_addr), .cpu_wdata(c1_wdata),
    .cpu_lock(c1_lock), .cpu_ack(c1_ack), .cpu_rdata(c1_rdata),
    .dma_req(d1_req), .dma_we(d1_we), .dma_addr(d1_addr), .dma_wdata(d1_wdata),
    .dma_ack(d1_ack), .dma_rdata(d1_rdata),
    .ram_en(r1_en), .ram_we(r1_we), .ram_addr(r1_addr), .ram_wdata(r1_wdata),
    .ram_rdata(r1_rdata), .busy(busy1), .owner(owner1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]  <= 8'(i) ^ 8'h5A;
      mem1[i] <= 8'h00;
    end
    mem1[8'h10] <= 8'hA5;
  end

  // Behavioural RAMs: read data appears RD_LAT cycles after the strobe, junk otherwise.
  always @(posedge clk) begin
    if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
    pipe[0] <= (ram_en && !ram_we) ? mem[ram_addr] : 8'hEE;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    if (r1_en && r1_we) mem1[r1_addr] <= r1_wdata;
    r1_rdata <= (r1_en && !r1_we) ? mem1[r1_addr] : 8'hEE;
  end
  assign ram_rdata = pipe[LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic issue(input logic who, input logic we, input logic [7:0] addr,
                       input logic [7:0] wd, input logic lock, input int exp_en);
    txn_t t;
    t.we     = we;
    t.addr   = addr;
    t.wdata  = wd;
    t.rdata  = we ? 8'h00 : shadow[addr];
    t.exp_en = exp_en;
    if (we) shadow[addr] = wd;
    ack_snap[who] = ack_cnt[who];
    exp_q[who].push_back(t);
    if (who == 1'b0) begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_lock = lock;
    end else begin
      dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wd;
    end
  endtask

  task automatic wait_ack(input logic who);
    int n = 0;
    while (ack_cnt[who] == ack_snap[who] && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (n >= 200) chk(who ? "dma_ack_timeout" : "cpu_ack_timeout", 32'd0, 32'd1);
    #1;
    if (who == 1'b0) begin
      cpu_req = 1'b0; cpu_lock = 1'b0;
    end else begin
      dma_req = 1'b0;
    end
  endtask

  task automatic run_seq(input logic who, input int n, input int max_gap);
    logic we;
    logic [7:0] a, d;
    int gap;
    for (int i = 0; i < n; i++) begin
      we  = 1'($urandom_range(0, 1));
      a   = {who, 7'($urandom_range(0, 127))};
      d   = 8'($urandom);
      issue(who, we, a, d, 1'b0, -1);
      wait_ack(who);
      gap = $urandom_range(0, max_gap);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
  endtask

  // Monitor: checks each grant against the queued request, each ack against latency and data.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("ram_we_without_en", 32'(ram_we & ~ram_en), 32'd0);
      if (ram_en) begin
        grant_log.push_back(owner);
        en_cyc[owner] = cyc;
        chk("busy_at_issue", 32'(busy), 32'd1);
        if (exp_q[owner].size() == 0) begin
          chk("grant_without_request", 32'd1, 32'd0);
        end else begin
          mt = exp_q[owner][0];
          chk("grant_we", 32'(ram_we), 32'(mt.we));
          chk("grant_addr", 32'(ram_addr), 32'(mt.addr));
          if (mt.we) chk("grant_wdata", 32'(ram_wdata), 32'(mt.wdata));
          if (mt.exp_en >= 0) chk("grant_cycle", 32'(cyc), 32'(mt.exp_en));
        end
      end
      for (int w = 0; w < 2; w++) begin
        m_ack = (w == 0) ? cpu_ack : dma_ack;
        m_rd  = (w == 0) ? cpu_rdata : dma_rdata;
        m_ex  = last_rd[w];
        if (m_ack) begin
          ack_cnt[w]++;
          ack_cyc[w] = cyc;
          if (exp_q[w].size() == 0) begin
            chk("ack_without_request", 32'd1, 32'd0);
          end else begin
            mt = exp_q[w].pop_front();
            chk("ack_latency", 32'(cyc - en_cyc[w]), mt.we ? 32'd1 : 32'(1 + LAT));
            if (!mt.we) m_ex = mt.rdata;
          end
        end
        chk((w == 0) ? "cpu_rdata" : "dma_rdata", 32'(m_rd), 32'(m_ex));
        last_rd[w] = m_ex;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, g0, en_c, ack_c, acks1, snap;
    logic [7:0] rd1;
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_lock = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    c1_req = 0; c1_we = 0; c1_addr = 0; c1_wdata = 0; c1_lock = 0;
    d1_req = 0; d1_we = 0; d1_addr = 0; d1_wdata = 0;
    for (int i = 0; i < 256; i++) shadow[i] = 8'(i) ^ 8'h5A;
    for (int w = 0; w < 2; w++) begin
      ack_cnt[w] = 0; ack_snap[w] = 0; ack_cyc[w] = 0; en_cyc[w] = 0; last_rd[w] = 8'h00;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_acks", 32'({cpu_ack, dma_ack}), 32'd0);
    chk("rst_rdata", 32'({cpu_rdata, dma_rdata}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    mon_en = 1'b1;

    // RD_LAT=1 instance: read of 0xA5 at 0x10.
    t = cyc; en_c = -1; ack_c = -1; acks1 = 0; rd1 = 8'h00;
    c1_req = 1'b1; c1_we = 1'b0; c1_addr = 8'h10;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (r1_en && en_c < 0) en_c = cyc;
      if (c1_ack) begin
        acks1++; ack_c = cyc; rd1 = c1_rdata; c1_req = 1'b0;
      end
    end
    chk("lat1_ram_en_cycle", 32'(en_c), 32'(t + 1));
    chk("lat1_ack_cycle", 32'(ack_c), 32'(t + 3));
    chk("lat1_rdata", 32'(rd1), 32'hA5);
    chk("lat1_ack_count", 32'(acks1), 32'd1);
    @(posedge clk); #1;

    // Simultaneous CPU write / DMA read of the same address after reset: CPU first.
    g0 = grant_log.size();
    t = cyc;
    issue(1'b0, 1'b1, 8'h20, 8'h55, 1'b0, t + 1);
    issue(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, t + 4);
    wait_ack(1'b0);
    wait_ack(1'b1);
    chk("t2_grant_count", 32'(grant_log.size() - g0), 32'd2);

    // Continuous contention: grants alternate starting with the CPU.
    g0 = grant_log.size();
    fork
      run_seq(1'b0, 4, 0);
      run_seq(1'b1, 4, 0);
    join
    chk("rr_grant_count", 32'(grant_log.size() - g0), 32'd8);
    for (int i = 0; i < 8 && g0 + i < grant_log.size(); i++)
      chk("rr_grant_owner", 32'(grant_log[g0 + i]), 32'(i % 2));

    // Locked CPU pair with DMA pending (and a CPU idle gap while locked).
    g0 = grant_log.size();
    t = cyc;
    issue(1'b0, 1'b1, 8'h30, 8'hC3, 1'b1, t + 1);
    @(posedge clk); #1;
    issue(1'b1, 1'b0, 8'h90, 8'h00, 1'b0, -1);
    wait_ack(1'b0);
    repeat (3) @(posedge clk);
    #1;
    issue(1'b0, 1'b1, 8'h31, 8'h3C, 1'b0, cyc + 1);
    wait_ack(1'b0);
    wait_ack(1'b1);
    chk("lock_grant_count", 32'(grant_log.size() - g0), 32'd3);
    for (int i = 0; i < 3 && g0 + i < grant_log.size(); i++)
      chk("lock_grant_owner", 32'(grant_log[g0 + i]), (i == 2) ? 32'd1 : 32'd0);
    chk("lock_dma_follows", 32'(en_cyc[1]), 32'(ack_cyc[0] + 2));

    // Lone DMA read with RD_LAT=3.
    snap = ack_cnt[0];
    t = cyc;
    issue(1'b1, 1'b0, 8'h91, 8'h00, 1'b0, t + 1);
    wait_ack(1'b1);
    chk("dma_read_ack_cycle", 32'(ack_cyc[1]), 32'(t + 5));
    chk("no_cpu_ack_on_dma", 32'(ack_cnt[0]), 32'(snap));

    // Randomised traffic in disjoint address halves.
    fork
      run_seq(1'b0, 12, 3);
      run_seq(1'b1, 12, 3);
    join

    // Reset during WAIT aborts the read.
    issue(1'b0, 1'b1, 8'h05, 8'hA7, 1'b0, -1);
    wait_ack(1'b0);
    issue(1'b0, 1'b0, 8'h05, 8'h00, 1'b0, -1);
    wait_ack(1'b0);
    t = cyc;
    issue(1'b0, 1'b0, 8'h06, 8'h00, 1'b0, t + 1);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    mon_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    cpu_req = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ram_en", 32'(ram_en), 32'd0);
    chk("abort_acks", 32'({cpu_ack, dma_ack}), 32'd0);
    chk("abort_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("abort_dma_rdata", 32'(dma_rdata), 32'd0);
    exp_q[0].delete();
    exp_q[1].delete();
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    mon_en = 1'b1;
    snap = ack_cnt[0] + ack_cnt[1];
    repeat (6) @(negedge clk);
    chk("abort_no_ack", 32'(ack_cnt[0] + ack_cnt[1]), 32'(snap));
    @(posedge clk); #1;
    t = cyc;
    issue(1'b0, 1'b0, 8'h06, 8'h00, 1'b0, t + 1);
    wait_ack(1'b0);
    chk("post_reset_ack_cycle", 32'(ack_cyc[0]), 32'(t + 2 + LAT));

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
